// File: rtl/ex_mem_stage_buffer.sv
// EX->MEM pipeline register with valid bit, bubble insertion on EX stall,
// hold on MEM stall, flush, a feedback store for multi-cycle EX state
// (partial HI/LO result and cycle count), and a saturating bubble counter.
module ex_mem_stage_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int MEM_OP_WIDTH = 4,
    parameter int CNT_WIDTH    = 2,
    parameter int PERF_WIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    stall_ex,
    input  logic                    stall_mem,
    input  logic                    ex_valid,
    input  logic                    ex_write_enable,
    input  logic [ADDR_WIDTH-1:0]   ex_write_addr,
    input  logic [DATA_WIDTH-1:0]   ex_write_data,
    input  logic                    ex_write_hilo_enable,
    input  logic [DATA_WIDTH-1:0]   ex_write_hi_data,
    input  logic [DATA_WIDTH-1:0]   ex_write_lo_data,
    input  logic [MEM_OP_WIDTH-1:0] ex_mem_op,
    input  logic [DATA_WIDTH-1:0]   ex_mem_addr,
    input  logic [DATA_WIDTH-1:0]   ex_mem_store_data,
    input  logic [2*DATA_WIDTH-1:0] ex_hilo_temp,
    input  logic [CNT_WIDTH-1:0]    ex_cycle_count,
    output logic                    mem_valid,
    output logic                    mem_write_enable,
    output logic [ADDR_WIDTH-1:0]   mem_write_addr,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    output logic                    mem_write_hilo_enable,
    output logic [DATA_WIDTH-1:0]   mem_write_hi_data,
    output logic [DATA_WIDTH-1:0]   mem_write_lo_data,
    output logic [MEM_OP_WIDTH-1:0] mem_mem_op,
    output logic [DATA_WIDTH-1:0]   mem_mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_mem_store_data,
    output logic [2*DATA_WIDTH-1:0] hilo_temp_o,
    output logic [CNT_WIDTH-1:0]    cycle_count_o,
    output logic [PERF_WIDTH-1:0]   bubble_count
);

    // Forward-path payload: everything MEM consumes, bundled so that
    // bubble/flush can zero it in one assignment.
    typedef struct packed {
        logic                    valid;
        logic                    write_enable;
        logic [ADDR_WIDTH-1:0]   write_addr;
        logic [DATA_WIDTH-1:0]   write_data;
        logic                    write_hilo_enable;
        logic [DATA_WIDTH-1:0]   write_hi_data;
        logic [DATA_WIDTH-1:0]   write_lo_data;
        logic [MEM_OP_WIDTH-1:0] mem_op;
        logic [DATA_WIDTH-1:0]   mem_addr;
        logic [DATA_WIDTH-1:0]   mem_store_data;
    } fwd_t;

    localparam logic [PERF_WIDTH-1:0] PERF_ONE = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

    fwd_t ex_fwd;
    fwd_t mem_q;

    assign ex_fwd = '{
        valid:             ex_valid,
        write_enable:      ex_write_enable,
        write_addr:        ex_write_addr,
        write_data:        ex_write_data,
        write_hilo_enable: ex_write_hilo_enable,
        write_hi_data:     ex_write_hi_data,
        write_lo_data:     ex_write_lo_data,
        mem_op:            ex_mem_op,
        mem_addr:          ex_mem_addr,
        mem_store_data:    ex_mem_store_data
    };

    // Pipeline register: reset > flush > advance / bubble / hold.
    // The stall_ex=0, stall_mem=1 case cannot legally happen and falls into hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q         <= '0;
            hilo_temp_o   <= '0;
            cycle_count_o <= '0;
            bubble_count  <= '0;
        end else if (flush) begin
            mem_q         <= '0;
            hilo_temp_o   <= '0;
            cycle_count_o <= '0;
        end else if (!stall_ex && !stall_mem) begin
            mem_q         <= ex_fwd;
            hilo_temp_o   <= '0;
            cycle_count_o <= '0;
        end else if (stall_ex && !stall_mem) begin
            mem_q         <= '0;
            hilo_temp_o   <= ex_hilo_temp;
            cycle_count_o <= ex_cycle_count;
            if (bubble_count != '1)
                bubble_count <= bubble_count + PERF_ONE;
        end else begin
            hilo_temp_o   <= ex_hilo_temp;
            cycle_count_o <= ex_cycle_count;
        end
    end

    assign mem_valid             = mem_q.valid;
    assign mem_write_enable      = mem_q.write_enable;
    assign mem_write_addr        = mem_q.write_addr;
    assign mem_write_data        = mem_q.write_data;
    assign mem_write_hilo_enable = mem_q.write_hilo_enable;
    assign mem_write_hi_data     = mem_q.write_hi_data;
    assign mem_write_lo_data     = mem_q.write_lo_data;
    assign mem_mem_op            = mem_q.mem_op;
    assign mem_mem_addr          = mem_q.mem_addr;
    assign mem_mem_store_data    = mem_q.mem_store_data;

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// Scoreboard bench for ex_mem_stage_buffer: directed scenarios followed by
// random traffic; a behavioural model pushes expected outputs, a monitor
// pops and compares one cycle later. A second instance with a 2-bit bubble
// counter exercises saturation.
module tb_ex_mem_stage_buffer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 4;
    localparam int CW = 2;
    localparam int PW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, flush, stall_ex, stall_mem;
    logic          ex_valid, ex_write_enable, ex_write_hilo_enable;
    logic [AW-1:0] ex_write_addr;
    logic [DW-1:0] ex_write_data, ex_write_hi_data, ex_write_lo_data;
    logic [OW-1:0] ex_mem_op;
    logic [DW-1:0] ex_mem_addr, ex_mem_store_data;
    logic [2*DW-1:0] ex_hilo_temp;
    logic [CW-1:0] ex_cycle_count;

    logic          mem_valid, mem_write_enable, mem_write_hilo_enable;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data, mem_write_hi_data, mem_write_lo_data;
    logic [OW-1:0] mem_mem_op;
    logic [DW-1:0] mem_mem_addr, mem_mem_store_data;
    logic [2*DW-1:0] hilo_temp_o;
    logic [CW-1:0] cycle_count_o;
    logic [PW-1:0] bubble_count;

    logic          s_valid, s_write_enable, s_write_hilo_enable;
    logic [AW-1:0] s_write_addr;
    logic [DW-1:0] s_write_data, s_write_hi_data, s_write_lo_data;
    logic [OW-1:0] s_mem_op;
    logic [DW-1:0] s_mem_addr, s_mem_store_data;
    logic [2*DW-1:0] s_hilo_temp;
    logic [CW-1:0] s_cycle_count;
    logic [1:0]    s_bubble_count;

    ex_mem_stage_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_OP_WIDTH(OW),
                          .CNT_WIDTH(CW), .PERF_WIDTH(PW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .ex_valid(ex_valid), .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
        .ex_write_data(ex_write_data), .ex_write_hilo_enable(ex_write_hilo_enable),
        .ex_write_hi_data(ex_write_hi_data), .ex_write_lo_data(ex_write_lo_data),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_store_data(ex_mem_store_data),
        .ex_hilo_temp(ex_hilo_temp), .ex_cycle_count(ex_cycle_count),
        .mem_valid(mem_valid), .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_hilo_enable(mem_write_hilo_enable),
        .mem_write_hi_data(mem_write_hi_data), .mem_write_lo_data(mem_write_lo_data),
        .mem_mem_op(mem_mem_op), .mem_mem_addr(mem_mem_addr), .mem_mem_store_data(mem_mem_store_data),
        .hilo_temp_o(hilo_temp_o), .cycle_count_o(cycle_count_o), .bubble_count(bubble_count)
    );

    ex_mem_stage_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_OP_WIDTH(OW),
                          .CNT_WIDTH(CW), .PERF_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .ex_valid(ex_valid), .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
        .ex_write_data(ex_write_data), .ex_write_hilo_enable(ex_write_hilo_enable),
        .ex_write_hi_data(ex_write_hi_data), .ex_write_lo_data(ex_write_lo_data),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_store_data(ex_mem_store_data),
        .ex_hilo_temp(ex_hilo_temp), .ex_cycle_count(ex_cycle_count),
        .mem_valid(s_valid), .mem_write_enable(s_write_enable), .mem_write_addr(s_write_addr),
        .mem_write_data(s_write_data), .mem_write_hilo_enable(s_write_hilo_enable),
        .mem_write_hi_data(s_write_hi_data), .mem_write_lo_data(s_write_lo_data),
        .mem_mem_op(s_mem_op), .mem_mem_addr(s_mem_addr), .mem_mem_store_data(s_mem_store_data),
        .hilo_temp_o(s_hilo_temp), .cycle_count_o(s_cycle_count), .bubble_count(s_bubble_count)
    );

    // Expected post-edge view of the block.
    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          hwe;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [OW-1:0] op;
        logic [DW-1:0] ma;
        logic [DW-1:0] sd;
        logic [2*DW-1:0] hilo;
        logic [CW-1:0] cnt;
        logic [PW-1:0] bub;
        logic [1:0]    bub2;
    } exp_t;

    exp_t model_state;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next expected state from the current inputs, following the block's rules.
    function automatic exp_t next_state(input exp_t cur);
        exp_t n;
        n = cur;
        if (reset) begin
            n = '0;
        end else if (flush) begin
            n = '0;
            n.bub  = cur.bub;
            n.bub2 = cur.bub2;
        end else if (!stall_ex) begin
            n.valid = ex_valid;             n.we = ex_write_enable;
            n.wa    = ex_write_addr;        n.wd = ex_write_data;
            n.hwe   = ex_write_hilo_enable; n.hi = ex_write_hi_data;
            n.lo    = ex_write_lo_data;     n.op = ex_mem_op;
            n.ma    = ex_mem_addr;          n.sd = ex_mem_store_data;
            n.hilo  = '0;                   n.cnt = '0;
        end else if (!stall_mem) begin
            n = '0;
            n.hilo = ex_hilo_temp;
            n.cnt  = ex_cycle_count;
            n.bub  = (cur.bub == 16'hFFFF) ? cur.bub : cur.bub + 16'd1;
            n.bub2 = (cur.bub2 == 2'd3) ? cur.bub2 : cur.bub2 + 2'd1;
        end else begin
            n.hilo = ex_hilo_temp;
            n.cnt  = ex_cycle_count;
        end
        return n;
    endfunction

    // Issue the currently driven inputs for one clock, record expectation.
    task automatic step();
        model_state = next_state(model_state);
        sb.push_back(model_state);
        @(negedge clock);
    endtask

    task automatic set_ex(input logic v, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [OW-1:0] op,
                          input logic [DW-1:0] ma, input logic [2*DW-1:0] ht,
                          input logic [CW-1:0] cc);
        ex_valid = v; ex_write_enable = we; ex_write_addr = wa; ex_write_data = wd;
        ex_write_hilo_enable = 1'b0; ex_write_hi_data = '0; ex_write_lo_data = '0;
        ex_mem_op = op; ex_mem_addr = ma; ex_mem_store_data = '0;
        ex_hilo_temp = ht; ex_cycle_count = cc;
    endtask

    task automatic randomize_ex();
        ex_valid = 1'($urandom); ex_write_enable = 1'($urandom);
        ex_write_addr = AW'($urandom); ex_write_data = $urandom;
        ex_write_hilo_enable = 1'($urandom);
        ex_write_hi_data = $urandom; ex_write_lo_data = $urandom;
        ex_mem_op = OW'($urandom); ex_mem_addr = $urandom; ex_mem_store_data = $urandom;
        ex_hilo_temp = {$urandom, $urandom}; ex_cycle_count = CW'($urandom);
    endtask

    // The stall controller must never stall MEM without stalling EX.
    always @(posedge clock)
        if (reset === 1'b0)
            assert (!(stall_ex === 1'b0 && stall_mem === 1'b1))
                else $error("illegal stall combination");

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mem_valid",   64'(mem_valid),             64'(e.valid));
                chk("write_en",    64'(mem_write_enable),      64'(e.we));
                chk("write_addr",  64'(mem_write_addr),        64'(e.wa));
                chk("write_data",  64'(mem_write_data),        64'(e.wd));
                chk("hilo_en",     64'(mem_write_hilo_enable), 64'(e.hwe));
                chk("hi_data",     64'(mem_write_hi_data),     64'(e.hi));
                chk("lo_data",     64'(mem_write_lo_data),     64'(e.lo));
                chk("mem_op",      64'(mem_mem_op),            64'(e.op));
                chk("mem_addr",    64'(mem_mem_addr),          64'(e.ma));
                chk("store_data",  64'(mem_mem_store_data),    64'(e.sd));
                chk("hilo_temp",   hilo_temp_o,                e.hilo);
                chk("cycle_count", 64'(cycle_count_o),         64'(e.cnt));
                chk("bubble_cnt",  64'(bubble_count),          64'(e.bub));
                chk("sat_bubble",  64'(s_bubble_count),        64'(e.bub2));
                chk("sat_valid",   64'(s_valid),               64'(e.valid));
                chk("sat_hilo",    s_hilo_temp,                e.hilo);
            end
        end
    end

    initial begin
        int r;
        model_state = '0;
        reset = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        set_ex(1'b1, 1'b1, 5'd9, 32'h1234_5678, 4'h1, 32'h40, 64'hFFFF, 2'd3);

        // Reset for two cycles: everything reads zero.
        step(); step();

        // Pass-through of a GPR write.
        reset = 1'b0;
        set_ex(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 4'h0, 32'h0, 64'h0, 2'd0);
        step();

        // Five bubbles: MEM sees NOPs, feedback store captures EX, counters 1..5 / 1,2,3,3,3.
        stall_ex = 1'b1; stall_mem = 1'b0;
        set_ex(1'b1, 1'b1, 5'd7, 32'hAAAA_0000, 4'h2, 32'h200, 64'h1_0000_0002, 2'd1);
        repeat (5) step();

        // Load a store, then hold two cycles with different EX inputs.
        stall_ex = 1'b0;
        set_ex(1'b1, 1'b0, 5'd0, 32'h0, 4'h3, 32'h100, 64'h0, 2'd0);
        step();
        stall_ex = 1'b1; stall_mem = 1'b1;
        set_ex(1'b1, 1'b1, 5'd12, 32'h5555_5555, 4'h5, 32'h999, 64'h77, 2'd2);
        step(); step();

        // Flush wins over a bubble with a valid GPR write on EX.
        flush = 1'b1; stall_ex = 1'b1; stall_mem = 1'b0;
        set_ex(1'b1, 1'b1, 5'd21, 32'hCAFE_F00D, 4'h4, 32'h300, 64'h3_0000_0004, 2'd2);
        step();
        flush = 1'b0;

        // Reset in the middle of a held multi-cycle op, then advance.
        stall_ex = 1'b1; stall_mem = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        set_ex(1'b1, 1'b1, 5'd30, 32'h0BAD_CAFE, 4'h6, 32'h500, 64'h0, 2'd0);
        step();

        // Random traffic: legal stall combinations only, occasional flush/reset.
        for (int i = 0; i < 400; i++) begin
            randomize_ex();
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 2);
            stall_ex  = (r != 0);
            stall_mem = (r == 2);
            step();
        end

        // Drain scoreboard within a bounded number of cycles.
        reset = 1'b0; flush = 1'b0; stall_ex = 1'b1; stall_mem = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_buffer.md
Name: ex_mem_stage_buffer

Overview:
Parametrised EX→MEM pipeline register, successor to the plain EX/MEM latch. It carries register-file writeback, HI/LO writeback and load/store request fields from EX to MEM. It adds a valid bit, stall-driven bubble insertion, hold and flush. It also provides a feedback store so multi-cycle EX operations (madd/msub, iterative div) keep their partial result and cycle count while EX is stalled. A saturating counter reports how many bubbles the block has inserted.

Parameters:
DATA_WIDTH, 32, width of register, HI/LO, memory address and store-data fields
ADDR_WIDTH, 5, register-file address width
MEM_OP_WIDTH, 4, encoded load/store operation; 0 = no memory access
CNT_WIDTH, 2, width of the multi-cycle EX cycle counter
PERF_WIDTH, 16, width of the bubble counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard the in-flight EX instruction and the hold state (exception/branch redirect)
stall_ex  in  1  EX stage stalled this cycle
stall_mem  in  1  MEM stage stalled this cycle
ex_valid  in  1  EX holds a real instruction
ex_write_enable  in  1  GPR write request
ex_write_addr  in  ADDR_WIDTH  GPR destination
ex_write_data  in  DATA_WIDTH  GPR write data
ex_write_hilo_enable  in  1  HI/LO write request
ex_write_hi_data  in  DATA_WIDTH  HI value
ex_write_lo_data  in  DATA_WIDTH  LO value
ex_mem_op  in  MEM_OP_WIDTH  load/store op
ex_mem_addr  in  DATA_WIDTH  effective address
ex_mem_store_data  in  DATA_WIDTH  store data
ex_hilo_temp  in  2*DATA_WIDTH  partial multi-cycle result
ex_cycle_count  in  CNT_WIDTH  multi-cycle progress
mem_valid  out  1  registered copy of ex_valid
mem_write_enable, mem_write_addr, mem_write_data  out  1/ADDR_WIDTH/DATA_WIDTH  registered copies of the ex_write_* GPR fields
mem_write_hilo_enable, mem_write_hi_data, mem_write_lo_data  out  1/DATA_WIDTH/DATA_WIDTH  registered copies of the ex_write_hilo/hi/lo fields
mem_mem_op, mem_mem_addr, mem_mem_store_data  out  MEM_OP_WIDTH/DATA_WIDTH/DATA_WIDTH  registered copies of the ex_mem_* fields
hilo_temp_o  out  2*DATA_WIDTH  held partial result, fed back to EX
cycle_count_o  out  CNT_WIDTH  held cycle count, fed back to EX
bubble_count  out  PERF_WIDTH  bubbles inserted since reset

Behaviour:
- All state updates on the rising edge of clock. Forward-path latency is 1 cycle.
- Priority order: reset > flush > stall decode.
- Reset: every output is 0, and every enable/valid output is 0.
- Flush (reset=0): all mem_* outputs go to 0, including mem_valid and all enables. hilo_temp_o and cycle_count_o go to 0. bubble_count is unchanged.
- Stall decode when reset=0 and flush=0:
  - stall_ex=0, stall_mem=0 (advance): every mem_* output takes the matching ex_* input. hilo_temp_o and cycle_count_o clear to 0.
  - stall_ex=1, stall_mem=0 (bubble): all mem_* outputs go to 0, so MEM sees a NOP. hilo_temp_o takes ex_hilo_temp and cycle_count_o takes ex_cycle_count. bubble_count increments by 1 and saturates at all-ones.
  - stall_ex=1, stall_mem=1 (hold): mem_* outputs keep their values. hilo_temp_o and cycle_count_o still capture the EX inputs. bubble_count is unchanged.
  - stall_ex=0, stall_mem=1: illegal, because the stall controller must stall upstream of a stalled stage. The block treats it as hold. The bench asserts this combination never occurs.
- A bubble or flush forces all enables to 0, so no GPR, HI/LO or memory side effect leaks downstream. Data fields are also zeroed, giving deterministic waveforms.
- Enables are passed through as given, even when ex_valid=0. EX must already drive 0 enables for invalid slots.
- Reset or flush in the middle of a multi-cycle operation discards the partial result. The next cycle_count_o is 0.
- The block does no arithmetic except the bubble counter: it increments by +1 and saturates, with no wrap-around.

Test Plan:
1. Pass-through: reset 2 cycles, then ex_write_enable=1, addr=5'd3, data=32'hDEADBEEF, ex_valid=1, no stalls → next cycle mem_write_*=1/3/DEADBEEF, mem_valid=1; all outputs 0 during reset.
2. Bubble: stall_ex=1, stall_mem=0 for 3 cycles with ex_mem_op=4'h2, ex_hilo_temp=64'h1_0000_0002, ex_cycle_count=1 → mem_valid and mem_mem_op read 0 each cycle; hilo_temp_o=64'h1_0000_0002, cycle_count_o=1; bubble_count goes 0→3.
3. Hold: load a store (op=4'h3, addr=32'h100) in one cycle, then stall_ex=stall_mem=1 for 2 cycles with different EX inputs → mem_mem_op=3 and mem_mem_addr=32'h100 for both cycles; bubble_count unchanged.
4. Flush priority: assert flush together with stall_ex=1 and with a valid GPR write on EX → next cycle all mem_* outputs, hilo_temp_o and cycle_count_o read 0; bubble_count unchanged.
5. Saturation: with PERF_WIDTH=2, bubble 5 consecutive cycles → bubble_count goes 1,2,3,3,3.
6. Reset mid-operation: assert reset during a hold with cycle_count_o=2 → next cycle every output is 0. Then release reset and advance with valid inputs → outputs track the inputs after 1 cycle.
